// File: rtl/fetch_decode_unit_pkg.sv
// Shared definitions for the accumulator processor's fetch/decode stage:
// opcode values, FSM state encoding and instruction field widths.
package fetch_decode_unit_pkg;

  localparam int OPW  = 3;
  localparam int IMMW = 5;

  localparam logic [2:0] OP_PASSA = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_PASSB = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_NAND  = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;
  localparam logic [2:0] OP_JZ    = 3'b110;
  localparam logic [2:0] OP_JC    = 3'b111;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;

  // Opcodes up to NAND are handed straight to the ALU; the rest are jumps.
  function automatic logic is_alu_op(input logic [2:0] op);
    return op <= OP_NAND;
  endfunction

endpackage

// File: rtl/fetch_decode_unit_prog_mem.sv
// Program memory: 2**AW words, synchronous write, asynchronous read.
// Contents are deliberately not reset so a loaded program survives reset.
module fetch_decode_unit_prog_mem #(
  parameter int AW = 5,
  parameter int WW = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [WW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [WW-1:0] o_rdata
);

  logic [WW-1:0] r_mem [2**AW];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode/execute sequencer for the 5-bit accumulator processor.
// Define SINGLE_STEP_EN to add a 'step' input that gates each FETCH.
module fetch_decode_unit
  import fetch_decode_unit_pkg::*;
#(
  parameter int AW = 5,
  parameter int DW = IMMW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic              prog_we,
  input  logic [AW-1:0]     prog_addr,
  input  logic [OPW+DW-1:0] prog_data,
  input  logic              C,
  input  logic              ZE,
  output logic [2:0]        F,
  output logic [DW-1:0]     operand,
  output logic              enableDB,
  output logic              enableFF,
  output logic              enableR,
  output logic [AW-1:0]     pc,
  output logic              busy,
  output logic              halted
);

  logic [2:0]        r_state;
  logic [AW-1:0]     r_pc;
  logic [OPW+DW-1:0] r_ir;
  logic              r_c;
  logic              r_ze;

  logic [OPW+DW-1:0] w_memRd;
  logic              w_memWe;
  logic [2:0]        w_op;
  logic [DW-1:0]     w_imm;
  logic [AW-1:0]     w_immAddr;
  logic [AW-1:0]     w_pcMinus1;
  logic              w_isAlu;
  logic              w_taken;
  logic              w_haltIdiom;
  logic              w_fetchGo;
  logic              w_active;

  // The program can only be rewritten while nothing is executing.
  assign w_memWe = prog_we && ((r_state == IDLE) || (r_state == HALT));

  fetch_decode_unit_prog_mem #(
    .AW (AW),
    .WW (OPW + DW)
  ) u_prog_mem (
    .clk     (clk),
    .i_we    (w_memWe),
    .i_waddr (prog_addr),
    .i_wdata (prog_data),
    .i_raddr (r_pc),
    .o_rdata (w_memRd)
  );

`ifdef SINGLE_STEP_EN
  assign w_fetchGo = step;
`else
  assign w_fetchGo = 1'b1;
`endif

  assign w_op       = r_ir[OPW+DW-1:DW];
  assign w_imm      = r_ir[DW-1:0];
  assign w_immAddr  = AW'(w_imm);
  assign w_pcMinus1 = r_pc - AW'(1);
  assign w_isAlu    = is_alu_op(w_op);
  assign w_taken    = (w_op == OP_JMP) || ((w_op == OP_JZ) && r_ze) || ((w_op == OP_JC) && r_c);
  // pc already points past the instruction in EXEC, so "jump to self" is pc-1.
  assign w_haltIdiom = (w_op == OP_JMP) && (w_immAddr == w_pcMinus1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_c     <= 1'b0;
      r_ze    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (run) r_state <= FETCH;
        end
        FETCH: begin
          if (w_fetchGo) begin
            r_ir    <= w_memRd;
            r_pc    <= r_pc + AW'(1);
            r_c     <= C;
            r_ze    <= ZE;
            r_state <= DECODE;
          end
        end
        DECODE: r_state <= EXEC;
        EXEC: begin
          if (!w_isAlu && w_taken) r_pc <= w_immAddr;
          if (w_haltIdiom)  r_state <= HALT;
          else if (run)     r_state <= FETCH;
          else              r_state <= IDLE;
        end
        HALT: begin
          if (!run) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outputs depend only on state and ir, never on run/C/ZE.
  assign w_active = (r_state == DECODE) || (r_state == EXEC);
  assign F        = (w_active && w_isAlu) ? w_op : OP_PASSA;
  assign operand  = w_active ? w_imm : '0;
  assign enableDB = w_active && w_isAlu;
  assign enableFF = (r_state == EXEC) && w_isAlu;
  assign enableR  = (r_state == EXEC) && w_isAlu;
  assign pc       = r_pc;
  assign busy     = (r_state == FETCH) || w_active;
  assign halted   = (r_state == HALT);

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Self-checking bench for fetch_decode_unit: an instruction-level reference
// model feeds a scoreboard that a negedge monitor drains on every ALU EXEC.
module tb_fetch_decode_unit;

  localparam int MEMN = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       progWe;
  logic [4:0] progAddr;
  logic [7:0] progData;
  logic       cIn;
  logic       zeIn;
  logic [2:0] f;
  logic [4:0] operand;
  logic       enDB;
  logic       enFF;
  logic       enR;
  logic [4:0] pcOut;
  logic       busy;
  logic       halted;
`ifdef SINGLE_STEP_EN
  logic       step = 1'b1;
`endif

  fetch_decode_unit dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
`ifdef SINGLE_STEP_EN
    .step      (step),
`endif
    .prog_we   (progWe),
    .prog_addr (progAddr),
    .prog_data (progData),
    .C         (cIn),
    .ZE        (zeIn),
    .F         (f),
    .operand   (operand),
    .enableDB  (enDB),
    .enableFF  (enFF),
    .enableR   (enR),
    .pc        (pcOut),
    .busy      (busy),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] f;
    logic [4:0] opnd;
    logic [4:0] pc;
  } exp_t;

  exp_t       expQ[$];
  exp_t       monE;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] refMem [MEMN];
  int         refPc = 0;
  bit         flagC [16];
  bit         flagZ [16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard drain: every ALU execute cycle must match the next expected op.
  always @(negedge clk) begin
    if (enFF || enR) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected exec enableFF", {31'd0, enFF}, 32'd0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("exec F", {29'd0, f}, {29'd0, monE.f});
        checkOutput("exec operand", {27'd0, operand}, {27'd0, monE.opnd});
        checkOutput("exec pc", {27'd0, pcOut}, {27'd0, monE.pc});
        checkOutput("exec enableDB", {31'd0, enDB}, 32'd1);
        checkOutput("exec enableFF", {31'd0, enFF}, 32'd1);
        checkOutput("exec enableR", {31'd0, enR}, 32'd1);
      end
    end
  end

  // Instruction-level reference: walks the program, records ALU executes.
  task automatic modelRun(input int k, input int flagMode, output int n, output bit didHalt);
    logic [7:0] word;
    int op;
    int imm;
    int nextPc;
    n = 0;
    didHalt = 1'b0;
    while (n < k && !didHalt) begin
      word = refMem[refPc];
      op   = int'(word[7:5]);
      imm  = int'(word[4:0]);
      flagC[n] = (flagMode == 0) ? 1'($urandom_range(0, 1)) : (flagMode == 2);
      flagZ[n] = (flagMode == 0) ? 1'($urandom_range(0, 1)) : (flagMode == 2);
      nextPc = (refPc + 1) % MEMN;
      if (op <= 4) begin
        expQ.push_back('{word[7:5], word[4:0], 5'(nextPc)});
        refPc = nextPc;
      end else if (op == 5) begin
        if (imm == refPc) didHalt = 1'b1;
        refPc = imm;
      end else if (op == 6) begin
        refPc = flagZ[n] ? imm : nextPc;
      end else begin
        refPc = flagC[n] ? imm : nextPc;
      end
      n++;
    end
  endtask

  task automatic loadWord(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    progWe   = 1'b1;
    progAddr = a;
    progData = d;
    refMem[a] = d;
    @(negedge clk);
    progWe = 1'b0;
  endtask

  // Runs up to k instructions from IDLE, drops run inside the last one,
  // and randomly hammers prog_we while the FSM is busy.
  task automatic applyStimulus(input int k, input int flagMode, input int dropPh);
    int n;
    bit didHalt;
    int ph;
    int dropC;
    int expPc;
    modelRun(k, flagMode, n, didHalt);
    expPc = refPc;
    ph    = (dropPh < 0) ? int'($urandom_range(0, 2)) : dropPh;
    dropC = 3 * n - 2 + ph;
    for (int c = 0; c <= 3 * n + 3; c++) begin
      @(negedge clk);
      if (c == 0) run = 1'b1;
      if ((c % 3 == 0) && (c / 3 < n)) begin
        cIn  = flagC[c/3];
        zeIn = flagZ[c/3];
      end
      if (c == dropC) run = 1'b0;
      if (c >= 1 && c <= 3 * n) begin
        progWe   = 1'($urandom_range(0, 1));
        progAddr = 5'($urandom);
        progData = 8'($urandom);
      end else begin
        progWe = 1'b0;
      end
      if (c == 3 * n + 1) begin
        if (didHalt) checkOutput("halted after halt idiom", {31'd0, halted}, 32'd1);
        else         checkOutput("idle after run drop", {31'd0, busy}, 32'd0);
      end
    end
    checkOutput("pc at stop", {27'd0, pcOut}, 32'(expPc));
    checkOutput("busy at stop", {31'd0, busy}, 32'd0);
    checkOutput("halted at stop", {31'd0, halted}, 32'd0);
    checkOutput("pending execs", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit seen;
    reset    = 1'b0;
    run      = 1'b0;
    progWe   = 1'b0;
    progAddr = '0;
    progData = '0;
    cIn      = 1'b0;
    zeIn     = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset F", {29'd0, f}, 32'd0);
    checkOutput("reset operand", {27'd0, operand}, 32'd0);
    checkOutput("reset enableDB", {31'd0, enDB}, 32'd0);
    checkOutput("reset enableFF", {31'd0, enFF}, 32'd0);
    checkOutput("reset enableR", {31'd0, enR}, 32'd0);
    checkOutput("reset pc", {27'd0, pcOut}, 32'd0);
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    checkOutput("reset halted", {31'd0, halted}, 32'd0);
    reset = 1'b1;

    for (int a = 0; a < MEMN; a++) loadWord(5'(a), 8'($urandom));
    loadWord(5'd0, 8'b010_00011);
    loadWord(5'd1, 8'b011_00010);
    loadWord(5'd2, 8'b101_00010);
    applyStimulus(10, 0, -1);

    // Conditional jump taken, then not taken.
    loadWord(5'd2, 8'b110_01010);
    loadWord(5'd10, 8'b000_00111);
    applyStimulus(2, 2, -1);
    loadWord(5'd11, 8'b110_01010);
    loadWord(5'd12, 8'b011_00001);
    applyStimulus(2, 1, -1);

    // pc wrap from the last address.
    loadWord(5'd13, 8'b101_11111);
    loadWord(5'd31, 8'b000_00101);
    loadWord(5'd0, 8'b100_01001);
    applyStimulus(3, 0, -1);

    for (int ep = 0; ep < 20; ep++) begin
      for (int w = 0; w < 6; w++) begin
        int a;
        a = int'($urandom_range(0, MEMN - 1));
        if ($urandom_range(0, 7) == 0) loadWord(5'(a), {3'b101, 5'(a)});
        else                           loadWord(5'(a), 8'($urandom));
      end
      applyStimulus(int'($urandom_range(1, 12)), 0, -1);
    end

    // Asynchronous reset while an ALU op is executing.
    loadWord(5'(refPc), 8'b011_01001);
    expQ.push_back('{3'b011, 5'd9, 5'((refPc + 1) % MEMN)});
    @(negedge clk);
    run  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      seen = enFF;
    end
    checkOutput("exec reached before reset", {31'd0, seen}, 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("async reset enableFF", {31'd0, enFF}, 32'd0);
    checkOutput("async reset enableR", {31'd0, enR}, 32'd0);
    checkOutput("async reset pc", {27'd0, pcOut}, 32'd0);
    checkOutput("async reset busy", {31'd0, busy}, 32'd0);
    checkOutput("async reset halted", {31'd0, halted}, 32'd0);
    run   = 1'b0;
    refPc = 0;
    expQ.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Run drop in DECODE at address 4, then resume from address 5.
    for (int a = 0; a < 6; a++) loadWord(5'(a), {3'($urandom_range(0, 4)), 5'($urandom)});
    applyStimulus(5, 0, 1);
    applyStimulus(1, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
